// File: rtl/bp_pkg.sv
// Shared branch-prediction types: the prediction metadata that rides the
// pipeline alongside each fetched instruction, plus the sequential-PC helper.
package bp_pkg;

    localparam int XLEN = 32;

    // Byte distance from one instruction to the next in program order.
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

    // Prediction made at fetch time for one instruction.
    typedef struct packed {
        logic            valid;
        logic            find;
        logic            jmp;
        logic [XLEN-1:0] npc;
    } pred_meta_t;

    // Bubble record: what a flushed or reset pipeline slot holds.
    localparam pred_meta_t META_EMPTY = '{valid: 1'b0, find: 1'b0, jmp: 1'b0, npc: 32'd0};

    // Fall-through next PC; wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] seq_npc(input logic [XLEN-1:0] pc);
        return pc + INSN_BYTES;
    endfunction

endpackage

// File: rtl/pred_meta_reg.sv
// One pipeline stage for prediction metadata. Flush turns the slot into a
// bubble and wins over stall; stall holds; otherwise the upstream record loads.
module pred_meta_reg
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  pred_meta_t d,
    output pred_meta_t q
);

    pred_meta_t meta_r;

    // Stage register: reset, bubble on flush, hold on stall, else advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= META_EMPTY;
        end else if (flush) begin
            meta_r <= META_EMPTY;
        end else if (!stall) begin
            meta_r <= d;
        end else begin
            meta_r <= meta_r;
        end
    end

    assign q = meta_r;

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution: delays the fetch-time prediction to EX, compares it with
// the real next PC, raises a mispredict flush, emits a predictor update and
// keeps saturating branch / mispredict statistics.
module branch_resolve
    import bp_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          PC_IF,
    input  logic [31:0]          NPC_Pred_IF,
    input  logic                 find_IF,
    input  logic                 jmp_IF,
    input  logic                 stall_IFID,
    input  logic                 flush_IFID,
    input  logic                 stall_IDEX,
    input  logic                 flush_IDEX,
    input  logic                 is_br_EX,
    input  logic                 br_EX,
    input  logic [31:0]          PC_EX,
    input  logic [31:0]          br_target,
    output logic                 find_EX,
    output logic                 jmp_EX,
    output logic [31:0]          NPC_Pred_EX,
    output logic                 fail,
    output logic [31:0]          redirect_PC,
    output logic                 upd_valid,
    output logic                 upd_taken,
    output logic [31:0]          upd_PC,
    output logic [31:0]          upd_target,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    pred_meta_t          if_meta_s;
    pred_meta_t          id_meta_s;
    pred_meta_t          ex_meta_s;
    logic                taken_s;
    logic [31:0]         actual_npc_s;
    logic                resolve_s;
    logic                fail_s;
    logic [31:0]         redirect_s;
    logic                upd_req_s;
    logic                upd_valid_r;
    logic                upd_taken_r;
    logic [31:0]         upd_pc_r;
    logic [31:0]         upd_target_r;
    logic [CNT_WIDTH-1:0] br_cnt_r;
    logic [CNT_WIDTH-1:0] miss_cnt_r;

    // PC_IF identifies the fetch the prediction belongs to; only the
    // prediction itself needs to travel down the pipe.
    assign if_meta_s = '{valid: 1'b1, find: find_IF, jmp: jmp_IF, npc: NPC_Pred_IF};

    pred_meta_reg u_ifid (
        .clk   (clk),
        .rst   (rst),
        .stall (stall_IFID),
        .flush (flush_IFID),
        .d     (if_meta_s),
        .q     (id_meta_s)
    );

    pred_meta_reg u_idex (
        .clk   (clk),
        .rst   (rst),
        .stall (stall_IDEX),
        .flush (flush_IDEX),
        .d     (id_meta_s),
        .q     (ex_meta_s)
    );

    assign find_EX     = ex_meta_s.find;
    assign jmp_EX      = ex_meta_s.jmp;
    assign NPC_Pred_EX = ex_meta_s.npc;

    // EX resolution: real next PC, once-only resolve strobe, mispredict check.
    // A stalled EX instruction is not resolved yet; it resolves when released.
    always_comb begin
        taken_s      = is_br_EX & br_EX;
        actual_npc_s = seq_npc(PC_EX);
        if (taken_s) begin
            actual_npc_s = br_target;
        end else begin
            actual_npc_s = seq_npc(PC_EX);
        end
        resolve_s  = ex_meta_s.valid & ~stall_IDEX;
        upd_req_s  = resolve_s & (is_br_EX | ex_meta_s.find);
        fail_s     = 1'b0;
        redirect_s = 32'd0;
        if (resolve_s && (actual_npc_s != ex_meta_s.npc)) begin
            fail_s     = 1'b1;
            redirect_s = actual_npc_s;
        end else begin
            fail_s     = 1'b0;
            redirect_s = 32'd0;
        end
    end

    assign fail        = fail_s;
    assign redirect_PC = redirect_s;

    // Predictor update: one-cycle pulse after a resolved branch or a resolved
    // instruction the predictor claimed (so false hits get trained out).
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_r  <= 1'b0;
            upd_taken_r  <= 1'b0;
            upd_pc_r     <= 32'd0;
            upd_target_r <= 32'd0;
        end else if (upd_req_s) begin
            upd_valid_r  <= 1'b1;
            upd_taken_r  <= taken_s;
            upd_pc_r     <= PC_EX;
            upd_target_r <= actual_npc_s;
        end else begin
            upd_valid_r  <= 1'b0;
            upd_taken_r  <= upd_taken_r;
            upd_pc_r     <= upd_pc_r;
            upd_target_r <= upd_target_r;
        end
    end

    assign upd_valid  = upd_valid_r;
    assign upd_taken  = upd_taken_r;
    assign upd_PC     = upd_pc_r;
    assign upd_target = upd_target_r;

    // Statistics: saturating counters so long runs never alias back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_r   <= {CNT_WIDTH{1'b0}};
            miss_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (resolve_s && is_br_EX && (br_cnt_r != CNT_MAX)) begin
                br_cnt_r <= br_cnt_r + CNT_ONE;
            end else begin
                br_cnt_r <= br_cnt_r;
            end
            if (fail_s && (miss_cnt_r != CNT_MAX)) begin
                miss_cnt_r <= miss_cnt_r + CNT_ONE;
            end else begin
                miss_cnt_r <= miss_cnt_r;
            end
        end
    end

    assign br_cnt   = br_cnt_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_IF, NPC_Pred_IF, PC_EX, br_target;
    logic        find_IF, jmp_IF, stall_IFID, flush_IFID, stall_IDEX, flush_IDEX;
    logic        is_br_EX, br_EX;

    logic        find_EX, jmp_EX, fail, upd_valid, upd_taken;
    logic [31:0] NPC_Pred_EX, redirect_PC, upd_PC, upd_target, br_cnt, miss_cnt;

    logic        find4, jmp4, fail4, updv4, updt4;
    logic [31:0] npc4, redir4, updpc4, updtgt4;
    logic [3:0]  br_cnt4, miss_cnt4;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk(clk), .rst(rst), .PC_IF(PC_IF), .NPC_Pred_IF(NPC_Pred_IF),
        .find_IF(find_IF), .jmp_IF(jmp_IF), .stall_IFID(stall_IFID),
        .flush_IFID(flush_IFID), .stall_IDEX(stall_IDEX), .flush_IDEX(flush_IDEX),
        .is_br_EX(is_br_EX), .br_EX(br_EX), .PC_EX(PC_EX), .br_target(br_target),
        .find_EX(find_EX), .jmp_EX(jmp_EX), .NPC_Pred_EX(NPC_Pred_EX), .fail(fail),
        .redirect_PC(redirect_PC), .upd_valid(upd_valid), .upd_taken(upd_taken),
        .upd_PC(upd_PC), .upd_target(upd_target), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    branch_resolve #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .PC_IF(PC_IF), .NPC_Pred_IF(NPC_Pred_IF),
        .find_IF(find_IF), .jmp_IF(jmp_IF), .stall_IFID(stall_IFID),
        .flush_IFID(flush_IFID), .stall_IDEX(stall_IDEX), .flush_IDEX(flush_IDEX),
        .is_br_EX(is_br_EX), .br_EX(br_EX), .PC_EX(PC_EX), .br_target(br_target),
        .find_EX(find4), .jmp_EX(jmp4), .NPC_Pred_EX(npc4), .fail(fail4),
        .redirect_PC(redir4), .upd_valid(updv4), .upd_taken(updt4),
        .upd_PC(updpc4), .upd_target(updtgt4), .br_cnt(br_cnt4), .miss_cnt(miss_cnt4)
    );

    // ---------------- behavioural reference model ----------------
    // Each pipeline slot holds the prediction of one instruction; 'k' says the
    // find/jmp/npc fields have a defined value (not a flushed leftover).
    typedef struct { bit v; bit f; bit j; bit k; logic [31:0] n; } slot_t;
    slot_t       m_id, m_ex;
    bit          m_upd_v, m_upd_t;
    logic [31:0] m_upd_pc, m_upd_tgt;
    longint      m_br, m_miss;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] real_npc();
        return (is_br_EX && br_EX) ? br_target : PC_EX + 32'd4;
    endfunction

    function automatic logic [31:0] sat(input longint c, input longint mx);
        return (c > mx) ? mx[31:0] : c[31:0];
    endfunction

    task automatic model_check();
        bit          res;
        bit          ef;
        logic [31:0] a;
        res = m_ex.v && !stall_IDEX;
        a   = real_npc();
        ef  = res && (a != m_ex.n);
        chk("fail", {31'd0, fail}, {31'd0, ef});
        chk("fail_w4", {31'd0, fail4}, {31'd0, ef});
        chk("redirect_PC", redirect_PC, ef ? a : 32'd0);
        if (m_ex.k) begin
            chk("find_EX", {31'd0, find_EX}, {31'd0, m_ex.f});
            chk("jmp_EX", {31'd0, jmp_EX}, {31'd0, m_ex.j});
            chk("NPC_Pred_EX", NPC_Pred_EX, m_ex.n);
        end
        chk("upd_valid", {31'd0, upd_valid}, {31'd0, m_upd_v});
        if (m_upd_v) begin
            chk("upd_PC", upd_PC, m_upd_pc);
            chk("upd_taken", {31'd0, upd_taken}, {31'd0, m_upd_t});
            chk("upd_target", upd_target, m_upd_tgt);
        end
        chk("br_cnt", br_cnt, sat(m_br, 64'hFFFF_FFFF));
        chk("miss_cnt", miss_cnt, sat(m_miss, 64'hFFFF_FFFF));
        chk("br_cnt_w4", {28'd0, br_cnt4}, sat(m_br, 64'd15));
        chk("miss_cnt_w4", {28'd0, miss_cnt4}, sat(m_miss, 64'd15));
    endtask

    task automatic model_step();
        bit          res;
        logic [31:0] a;
        if (rst) begin
            m_id = '{0, 0, 0, 1, 32'd0};
            m_ex = '{0, 0, 0, 1, 32'd0};
            m_upd_v = 0; m_upd_t = 0; m_upd_pc = 32'd0; m_upd_tgt = 32'd0;
            m_br = 0; m_miss = 0;
        end else begin
            res = m_ex.v && !stall_IDEX;
            a   = real_npc();
            if (res && (is_br_EX || m_ex.f)) begin
                m_upd_v = 1; m_upd_pc = PC_EX; m_upd_t = is_br_EX && br_EX; m_upd_tgt = a;
            end else begin
                m_upd_v = 0;
            end
            if (res && is_br_EX) m_br++;
            if (res && a != m_ex.n) m_miss++;
            if (flush_IDEX)       m_ex = '{0, 0, 0, 0, 32'd0};
            else if (!stall_IDEX) m_ex = m_id;
            if (flush_IFID)       m_id = '{0, 0, 0, 0, 32'd0};
            else if (!stall_IFID) m_id = '{1, find_IF, jmp_IF, 1, NPC_Pred_IF};
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
        model_check();
    endtask

    task automatic end_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        at_neg();
        end_cycle();
    endtask

    task automatic idle_inputs();
        find_IF = 0; jmp_IF = 0; NPC_Pred_IF = 32'd0; PC_IF = 32'd0;
        stall_IFID = 0; flush_IFID = 0; stall_IDEX = 0; flush_IDEX = 0;
        is_br_EX = 0; br_EX = 0; PC_EX = 32'd0; br_target = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic find_if; logic jmp_if; logic [31:0] npc_if;
        logic [31:0] pc_ex; logic is_br; logic br; logic [31:0] tgt;
        logic e_fail; logic [31:0] e_redir; logic e_upd; logic e_taken; logic [31:0] e_tgt;
        int e_br; int e_miss;
    } vec_t;
    vec_t vecs[6];

    // Load one prediction into EX with bubbles around it, present the EX
    // side inputs, then return with EX set back to idle.
    task automatic load_to_ex(input logic f, input logic j, input logic [31:0] n);
        find_IF = f; jmp_IF = j; NPC_Pred_IF = n; PC_IF = 32'h100;
        cycle();
        flush_IFID = 1; find_IF = 0; jmp_IF = 0; NPC_Pred_IF = 32'd0;
        cycle();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        do_reset();
        load_to_ex(v.find_if, v.jmp_if, v.npc_if);
        PC_EX = v.pc_ex; is_br_EX = v.is_br; br_EX = v.br; br_target = v.tgt;
        at_neg();
        chk($sformatf("vec%0d_fail", idx), {31'd0, fail}, {31'd0, v.e_fail});
        chk($sformatf("vec%0d_redirect", idx), redirect_PC, v.e_redir);
        end_cycle();
        is_br_EX = 0; br_EX = 0; PC_EX = 32'd0; br_target = 32'd0;
        at_neg();
        chk($sformatf("vec%0d_upd_valid", idx), {31'd0, upd_valid}, {31'd0, v.e_upd});
        if (v.e_upd) begin
            chk($sformatf("vec%0d_upd_PC", idx), upd_PC, v.pc_ex);
            chk($sformatf("vec%0d_upd_taken", idx), {31'd0, upd_taken}, {31'd0, v.e_taken});
            chk($sformatf("vec%0d_upd_target", idx), upd_target, v.e_tgt);
        end
        chk($sformatf("vec%0d_br_cnt", idx), br_cnt, v.e_br);
        chk($sformatf("vec%0d_miss_cnt", idx), miss_cnt, v.e_miss);
        end_cycle();
    endtask

    initial begin
        vecs[0] = '{1, 1, 32'h200, 32'h100, 1, 1, 32'h200, 0, 32'h0,   1, 1, 32'h200, 1, 0};
        vecs[1] = '{0, 0, 32'h104, 32'h100, 1, 1, 32'h40,  1, 32'h40,  1, 1, 32'h40,  1, 1};
        vecs[2] = '{1, 1, 32'h300, 32'h120, 0, 0, 32'h0,   1, 32'h124, 1, 0, 32'h124, 0, 1};
        vecs[3] = '{0, 0, 32'h124, 32'h120, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   0, 0};
        vecs[4] = '{1, 0, 32'h104, 32'h100, 1, 0, 32'h80,  0, 32'h0,   1, 0, 32'h104, 1, 0};
        vecs[5] = '{0, 0, 32'h4,   32'hFFFF_FFFC, 0, 0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 0, 1};

        // Initial reset: bring model and DUT to the same state.
        idle_inputs();
        rst = 1;
        @(posedge clk);
        model_step();
        #1;
        rst = 0;
        at_neg();
        chk("rst_find_EX", {31'd0, find_EX}, 32'd0);
        chk("rst_jmp_EX", {31'd0, jmp_EX}, 32'd0);
        chk("rst_NPC_Pred_EX", NPC_Pred_EX, 32'd0);
        chk("rst_fail", {31'd0, fail}, 32'd0);
        chk("rst_redirect", redirect_PC, 32'd0);
        chk("rst_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
        end_cycle();

        // Two-cycle latency with no stalls.
        find_IF = 1; jmp_IF = 1; NPC_Pred_IF = 32'h5A0;
        cycle();
        idle_inputs();
        cycle();
        at_neg();
        chk("lat_NPC_Pred_EX", NPC_Pred_EX, 32'h5A0);
        chk("lat_find_EX", {31'd0, find_EX}, 32'd1);
        end_cycle();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Stall held 3 cycles on a mispredicting EX instruction.
        do_reset();
        load_to_ex(0, 0, 32'h104);
        PC_EX = 32'h100; is_br_EX = 1; br_EX = 1; br_target = 32'h40;
        stall_IDEX = 1; stall_IFID = 1;
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("stall_fail", {31'd0, fail}, 32'd0);
            chk("stall_upd_valid", {31'd0, upd_valid}, 32'd0);
            end_cycle();
        end
        stall_IDEX = 0; stall_IFID = 0;
        at_neg();
        chk("stall_release_fail", {31'd0, fail}, 32'd1);
        chk("stall_release_redirect", redirect_PC, 32'h40);
        end_cycle();
        idle_inputs(); flush_IFID = 1;
        at_neg();
        chk("stall_upd_pulse", {31'd0, upd_valid}, 32'd1);
        chk("stall_miss_cnt", miss_cnt, 32'd1);
        end_cycle();
        at_neg();
        chk("stall_upd_single", {31'd0, upd_valid}, 32'd0);
        chk("stall_miss_once", miss_cnt, 32'd1);
        end_cycle();

        // Flush and stall together on ID/EX: the instruction is dropped.
        do_reset();
        load_to_ex(0, 0, 32'h104);
        PC_EX = 32'h100; is_br_EX = 1; br_EX = 1; br_target = 32'h40;
        stall_IDEX = 1; flush_IDEX = 1;
        cycle();
        stall_IDEX = 0; flush_IDEX = 0;
        at_neg();
        chk("flush_fail", {31'd0, fail}, 32'd0);
        chk("flush_redirect", redirect_PC, 32'd0);
        end_cycle();
        at_neg();
        chk("flush_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("flush_miss_cnt", miss_cnt, 32'd0);
        end_cycle();

        // Reset in the same cycle as a resolve.
        do_reset();
        load_to_ex(0, 0, 32'h104);
        PC_EX = 32'h100; is_br_EX = 1; br_EX = 1; br_target = 32'h40;
        rst = 1;
        cycle();
        rst = 0;
        at_neg();
        chk("rstres_upd_valid", {31'd0, upd_valid}, 32'd0);
        chk("rstres_fail", {31'd0, fail}, 32'd0);
        chk("rstres_redirect", redirect_PC, 32'd0);
        chk("rstres_NPC_Pred_EX", NPC_Pred_EX, 32'd0);
        chk("rstres_find_EX", {31'd0, find_EX}, 32'd0);
        chk("rstres_upd_PC", upd_PC, 32'd0);
        chk("rstres_miss_cnt", miss_cnt, 32'd0);
        end_cycle();

        // 20 back-to-back mispredicts: the 4-bit counter must stick at 15.
        do_reset();
        PC_EX = 32'h100;
        for (int i = 0; i < 22; i++) cycle();
        at_neg();
        chk("sat_miss_cnt_w4", {28'd0, miss_cnt4}, 32'd15);
        chk("sat_miss_cnt_w32", miss_cnt, 32'd20);
        end_cycle();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            logic [31:0] pcs [4];
            pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h200; pcs[3] = 32'h40;
            rst         = ($urandom_range(0, 59) == 0);
            find_IF     = $urandom_range(0, 1) != 0;
            jmp_IF      = $urandom_range(0, 1) != 0;
            NPC_Pred_IF = pcs[$urandom_range(0, 3)];
            PC_IF       = $urandom;
            stall_IFID  = ($urandom_range(0, 4) == 0);
            flush_IFID  = ($urandom_range(0, 6) == 0);
            stall_IDEX  = ($urandom_range(0, 4) == 0);
            flush_IDEX  = ($urandom_range(0, 6) == 0);
            is_br_EX    = $urandom_range(0, 1) != 0;
            br_EX       = $urandom_range(0, 1) != 0;
            PC_EX       = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h3C;
            br_target   = ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h40;
            cycle();
        end
        rst = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
